excp: RTL

Exception/interrupt sequencer for the RV32 core, sitting beside the EX stage. It detects synchronous exceptions (ecall, ebreak, illegal instruction), `mret`, and (optionally) machine interrupts. It raises `excp_stallreq_o` toward the pipeline controller, which turns it into stall and flush, then performs the trap CSR writes and issues the PC redirect through a multi-cycle FSM.

---
 rtl/excp_if.sv | 35 +++
 rtl/excp.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/excp_if.sv
// EX-side event inputs, CSR values and trap/redirect outputs of the exception sequencer.
interface excp_if #(
   parameter int unsigned ADDR_W = 32
);
   logic              ex_valid_i;
   logic [ADDR_W-1:0] ex_inst_addr_i;
   logic              ex_ecall_i;
   logic              ex_ebreak_i;
   logic              ex_illegal_i;
   logic              ex_mret_i;
   logic              irq_timer_i;
   logic              irq_ext_i;
   logic [ADDR_W-1:0] csr_mstatus_i;
   logic [ADDR_W-1:0] csr_mie_i;
   logic [ADDR_W-1:0] csr_mtvec_i;
   logic [ADDR_W-1:0] csr_mepc_i;
   logic              csr_we_o;
   logic [11:0]       csr_waddr_o;
   logic [ADDR_W-1:0] csr_wdata_o;
   logic              jump_flag_o;
   logic [ADDR_W-1:0] jump_addr_o;
   logic [3:0]        excp_stallreq_o;

   modport master (
      output ex_valid_i, ex_inst_addr_i, ex_ecall_i, ex_ebreak_i, ex_illegal_i, ex_mret_i,
      output irq_timer_i, irq_ext_i, csr_mstatus_i, csr_mie_i, csr_mtvec_i, csr_mepc_i,
      input  csr_we_o, csr_waddr_o, csr_wdata_o, jump_flag_o, jump_addr_o, excp_stallreq_o
   );

   modport slave (
      input  ex_valid_i, ex_inst_addr_i, ex_ecall_i, ex_ebreak_i, ex_illegal_i, ex_mret_i,
      input  irq_timer_i, irq_ext_i, csr_mstatus_i, csr_mie_i, csr_mtvec_i, csr_mepc_i,
      output csr_we_o, csr_waddr_o, csr_wdata_o, jump_flag_o, jump_addr_o, excp_stallreq_o
   );
endinterface

// File: rtl/excp.sv
// Exception/interrupt sequencer: trap CSR writes and PC redirect via a multi-cycle FSM.
// Machine interrupt detection is compiled in only when EXCP_IRQ_EN is defined.
module excp #(
   parameter int unsigned       ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] MTVEC_RST = '0
) (
   input logic   clk,
   input logic   rst_n,
   excp_if.slave bus
);

   localparam logic [11:0] CsrMstatus = 12'h300;
   localparam logic [11:0] CsrMepc    = 12'h341;
   localparam logic [11:0] CsrMcause  = 12'h342;

   typedef enum logic [2:0] {
      StIdle, StWMepc, StWMcause, StWMstatus, StJump, StRMstatus, StJumpR
   } state_e;

   state_e            state_q;
   logic [ADDR_W-1:0] cause_q;
   logic [ADDR_W-1:0] epc_q;
   logic [3:0]        kind_q;

   logic              accept;
   logic              sync_evt;
   logic [ADDR_W-1:0] sync_cause;
   logic              irq_evt;
   logic [ADDR_W-1:0] irq_cause;
   logic              take_sync;
   logic              take_mret;
   logic              take_irq;
   logic              unused_bits;

   // Reset gates acceptance so every output reads 0 while rst_n is low.
   assign accept   = rst_n & bus.ex_valid_i & (state_q == StIdle);
   assign sync_evt = bus.ex_illegal_i | bus.ex_ecall_i | bus.ex_ebreak_i;

   always_comb begin
      sync_cause = ADDR_W'(3);
      if (bus.ex_illegal_i) begin
         sync_cause = ADDR_W'(2);
      end else if (bus.ex_ecall_i) begin
         sync_cause = ADDR_W'(11);
      end
   end

`ifdef EXCP_IRQ_EN
   logic irq_ext_take;
   logic irq_timer_take;

   assign irq_ext_take   = bus.csr_mstatus_i[3] & bus.csr_mie_i[11] & bus.irq_ext_i;
   assign irq_timer_take = bus.csr_mstatus_i[3] & bus.csr_mie_i[7] & bus.irq_timer_i;
   assign irq_evt        = irq_ext_take | irq_timer_take;
   assign irq_cause      = irq_ext_take ? {1'b1, (ADDR_W-1)'(11)} : {1'b1, (ADDR_W-1)'(7)};
`else
   assign irq_evt   = 1'b0;
   assign irq_cause = '0;
`endif

   assign unused_bits = ^{bus.csr_mie_i, bus.irq_timer_i, bus.irq_ext_i, bus.csr_mtvec_i[1:0]};

   assign take_sync = accept & sync_evt;
   assign take_mret = accept & ~sync_evt & bus.ex_mret_i;
   assign take_irq  = accept & ~sync_evt & ~bus.ex_mret_i & irq_evt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cause_q <= '0;
         epc_q   <= '0;
         kind_q  <= 4'b0000;
      end else begin
         case (state_q)
            StIdle: begin
               if (take_sync) begin
                  cause_q <= sync_cause;
                  epc_q   <= bus.ex_inst_addr_i;
                  kind_q  <= 4'b0100;
                  state_q <= StWMepc;
               end else if (take_mret) begin
                  kind_q  <= 4'b0010;
                  state_q <= StRMstatus;
               end else if (take_irq) begin
                  cause_q <= irq_cause;
                  epc_q   <= bus.ex_inst_addr_i + ADDR_W'(4);
                  kind_q  <= 4'b1000;
                  state_q <= StWMepc;
               end
            end
            StWMepc:    state_q <= StWMcause;
            StWMcause:  state_q <= StWMstatus;
            StWMstatus: state_q <= StJump;
            StRMstatus: state_q <= StJumpR;
            StJump, StJumpR: begin
               kind_q  <= 4'b0000;
               state_q <= StIdle;
            end
            default: begin
               kind_q  <= 4'b0000;
               state_q <= StIdle;
            end
         endcase
      end
   end

   always_comb begin
      bus.csr_we_o    = 1'b0;
      bus.csr_waddr_o = 12'h000;
      bus.csr_wdata_o = '0;
      bus.jump_flag_o = 1'b0;
      bus.jump_addr_o = '0;
      case (state_q)
         StWMepc: begin
            bus.csr_we_o    = 1'b1;
            bus.csr_waddr_o = CsrMepc;
            bus.csr_wdata_o = epc_q;
         end
         StWMcause: begin
            bus.csr_we_o    = 1'b1;
            bus.csr_waddr_o = CsrMcause;
            bus.csr_wdata_o = cause_q;
         end
         StWMstatus: begin
            bus.csr_we_o       = 1'b1;
            bus.csr_waddr_o    = CsrMstatus;
            bus.csr_wdata_o    = bus.csr_mstatus_i;
            bus.csr_wdata_o[7] = bus.csr_mstatus_i[3];
            bus.csr_wdata_o[3] = 1'b0;
         end
         StRMstatus: begin
            bus.csr_we_o       = 1'b1;
            bus.csr_waddr_o    = CsrMstatus;
            bus.csr_wdata_o    = bus.csr_mstatus_i;
            bus.csr_wdata_o[3] = bus.csr_mstatus_i[7];
            bus.csr_wdata_o[7] = 1'b1;
         end
         StJump: begin
            bus.jump_flag_o = 1'b1;
            if (bus.csr_mtvec_i[ADDR_W-1:2] == '0) begin
               bus.jump_addr_o = MTVEC_RST;
            end else begin
               bus.jump_addr_o = {bus.csr_mtvec_i[ADDR_W-1:2], 2'b00};
            end
         end
         StJumpR: begin
            bus.jump_flag_o = 1'b1;
            bus.jump_addr_o = bus.csr_mepc_i;
         end
         default: ;
      endcase
   end

   // IDLE reflects the event accepted this cycle; busy states reflect the latched one.
   always_comb begin
      if (state_q == StIdle) begin
         bus.excp_stallreq_o = {take_irq, take_sync, take_mret, accept & (sync_evt |
                                bus.ex_mret_i | irq_evt)};
      end else begin
         bus.excp_stallreq_o = kind_q | 4'b0001;
      end
   end

endmodule
